// File: rtl/fir_pkg.sv
// Shared constants for the unfolded FIR path: sample width, default lane count,
// and helpers that map a lane index onto its bit range inside a packed word.
package fir_pkg;

  localparam int NB    = 11;
  localparam int P_DEF = 3;

  typedef logic [NB-1:0] sample_t;

  function automatic int lane_lo(input int lane);
    return lane * NB;
  endfunction

  function automatic int lane_hi(input int lane);
    return (lane + 1) * NB - 1;
  endfunction

endpackage

// File: rtl/fir_unfold_sched_if.sv
// Serial sample side plus parallel core side of the unfolded FIR scheduler.
// The slave modport is the scheduler itself; the master is the surrounding system.
interface fir_unfold_sched_if
  import fir_pkg::*;
#(
  parameter int NB = fir_pkg::NB,
  parameter int P  = fir_pkg::P_DEF
);

  logic [NB-1:0]   DIN;
  logic            VIN;
  logic [P*NB-1:0] DU_O;
  logic            VU_O;
  logic [P*NB-1:0] DU_I;
  logic            VU_I;
  logic [NB-1:0]   DOUT;
  logic            VOUT;
  logic            OVF;

  modport master (
    output DIN, VIN, DU_I, VU_I,
    input  DU_O, VU_O, DOUT, VOUT, OVF
  );

  modport slave (
    input  DIN, VIN, DU_I, VU_I,
    output DU_O, VU_O, DOUT, VOUT, OVF
  );

endinterface

// File: rtl/fir_unfold_ser.sv
// Result serializer: captures one P-lane word from the core and plays its lanes
// out one per cycle, oldest lane first; words arriving mid-playout are dropped.
module fir_unfold_ser
  import fir_pkg::*;
#(
  parameter int P = P_DEF
) (
  input  logic            CLK,
  input  logic            RST_n,
  input  logic [P*NB-1:0] du_i,
  input  logic            vu_i,
  output logic [NB-1:0]   dout,
  output logic            vout,
  output logic            ovf
);

  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] LANE_LAST = CW'(P - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OUT  = 1'b1;

  logic [0:0]      state;
  logic [CW-1:0]   lane;
  logic [P*NB-1:0] res_q;

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state <= ST_IDLE;
      lane  <= '0;
      res_q <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (vu_i) begin
            res_q <= du_i;
            lane  <= '0;
            state <= ST_OUT;
          end
        end
        default: begin
          if (lane == LANE_LAST) begin
            // Last lane on the output: a new word here chains on with no bubble.
            if (vu_i) begin
              res_q <= du_i;
              lane  <= '0;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            lane <= lane + 1'b1;
            if (vu_i) ovf <= 1'b1;
          end
        end
      endcase
    end
  end

  // In IDLE the lane index rests on the last lane, so DOUT holds its final value.
  assign vout = (state == ST_OUT);
  assign dout = res_q[lane_lo(int'(lane)) +: NB];

endmodule

// File: rtl/fir_unfold_sched.sv
// Adapts the P-parallel unfolded FIR core to the serial DIN/VIN -> DOUT/VOUT flow:
// packs P valid samples into one core word and serializes core results back out.
module fir_unfold_sched
  import fir_pkg::*;
#(
  parameter int P = P_DEF
) (
  input  logic               CLK,
  input  logic               RST_n,
  fir_unfold_sched_if.slave  bus
);

  localparam int CW = $clog2(P);
  localparam logic [CW-1:0] CIN_LAST = CW'(P - 1);

  logic [CW-1:0]       cin;
  logic [(P-1)*NB-1:0] staging;
  logic [P*NB-1:0]     du_q;
  logic                vu_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      cin  <= '0;
      du_q <= '0;
      vu_q <= 1'b0;
    end else begin
      vu_q <= 1'b0;
      if (bus.VIN) begin
        if (cin == CIN_LAST) begin
          du_q <= {bus.DIN, staging};
          vu_q <= 1'b1;
          cin  <= '0;
        end else begin
          cin <= cin + 1'b1;
        end
      end
    end
  end

  // NOTE: staging is deliberately not reset: with cin back at 0 every lane is
  // rewritten before it can reach DU_O, so a reset would only cost routing.
  always_ff @(posedge CLK) begin
    if (bus.VIN && cin != CIN_LAST) staging[lane_lo(int'(cin)) +: NB] <= bus.DIN;
  end

  assign bus.DU_O = du_q;
  assign bus.VU_O = vu_q;

  fir_unfold_ser #(.P(P)) u_ser (
    .CLK   (CLK),
    .RST_n (RST_n),
    .du_i  (bus.DU_I),
    .vu_i  (bus.VU_I),
    .dout  (bus.DOUT),
    .vout  (bus.VOUT),
    .ovf   (bus.OVF)
  );

endmodule

// File: tb/tb_fir_unfold_sched.sv
// Bench for fir_unfold_sched: queue/timeline reference model of packer and serializer,
// directed scenarios plus a randomized core-loopback run.
module tb_fir_unfold_sched;
  import fir_pkg::*;

  localparam int P = P_DEF;
  localparam int W = P * NB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_unfold_sched_if #(.NB(NB), .P(P)) bus ();

  fir_unfold_sched #(.P(P)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Packer model: valid samples since reset, grouped P at a time.
  sample_t      pend[$];
  logic [W-1:0] exp_du_o;
  logic         exp_vu_o;
  int           pulses;

  // Serializer model: timeline of (cycle, value) that DOUT must show.
  typedef struct {
    int      t;
    sample_t v;
  } ev_t;
  ev_t     sched_q[$];
  int      free_at;
  sample_t exp_dout;
  logic    exp_vout;
  logic    exp_ovf;
  sample_t seen_q[$];

  // Advance one clock and update the model from the inputs applied before the edge.
  task automatic tick();
    logic         rst_s, vin_s, vui_s;
    sample_t      din_s;
    logic [W-1:0] dui_s;
    rst_s = rst_n;
    vin_s = bus.VIN;
    din_s = bus.DIN;
    vui_s = bus.VU_I;
    dui_s = bus.DU_I;
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_s) begin
      pend.delete();
      exp_du_o = '0;
      exp_vu_o = 1'b0;
      sched_q.delete();
      free_at  = 0;
      exp_dout = '0;
      exp_ovf  = 1'b0;
    end else begin
      exp_vu_o = 1'b0;
      if (vin_s) begin
        pend.push_back(din_s);
        if (pend.size() == P) begin
          for (int i = 0; i < P; i++) exp_du_o[i*NB +: NB] = pend[i];
          exp_vu_o = 1'b1;
          pend.delete();
        end
      end
      if (vui_s) begin
        if (cyc >= free_at) begin
          for (int j = 0; j < P; j++) sched_q.push_back('{cyc + j, dui_s[j*NB +: NB]});
          free_at = cyc + P;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    exp_vout = 1'b0;
    if (sched_q.size() > 0 && sched_q[0].t == cyc) begin
      exp_vout = 1'b1;
      exp_dout = sched_q[0].v;
      void'(sched_q.pop_front());
    end
    if (bus.VU_O) pulses++;
    if (bus.VOUT) seen_q.push_back(bus.DOUT);
  endtask

  task automatic idle_inputs();
    bus.VIN  = 1'b0;
    bus.DIN  = '0;
    bus.VU_I = 1'b0;
    bus.DU_I = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pulses = 0;
    seen_q.delete();
  endtask

  function automatic logic [W-1:0] pack3(input sample_t a, input sample_t b, input sample_t c);
    logic [W-1:0] w;
    w = '0;
    w[lane_hi(0):lane_lo(0)] = a;
    w[lane_hi(1):lane_lo(1)] = b;
    w[lane_hi(2):lane_lo(2)] = c;
    return w;
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.VIN  = 1'b1;
    bus.DIN  = sample_t'($urandom);
    bus.VU_I = 1'b1;
    bus.DU_I = W'({$urandom, $urandom});
    tick();
    tick();
    checks++;
    if ({bus.DU_O, bus.VU_O, bus.DOUT, bus.VOUT, bus.OVF} !== '0) begin
      errors++;
      $display("FAIL reset_state du_o=%h vu_o=%b dout=%h vout=%b ovf=%b required all zero",
               bus.DU_O, bus.VU_O, bus.DOUT, bus.VOUT, bus.OVF);
    end
    rst_n = 1'b1;
    idle_inputs();
    pulses = 0;
    seen_q.delete();
  endtask

  task automatic test_continuous();
    do_reset();
    for (int v = 1; v <= 10; v++) begin
      bus.VIN = (v <= 9);
      bus.DIN = sample_t'(v);
      tick();
      checks++;
      if ({bus.VU_O, bus.DU_O} !== {exp_vu_o, exp_du_o}) begin
        errors++;
        $display("FAIL continuous_pack cyc=%0d got vu=%b du=%h want vu=%b du=%h",
                 cyc, bus.VU_O, bus.DU_O, exp_vu_o, exp_du_o);
      end
      if (v == 3) begin
        checks++;
        if (bus.VU_O !== 1'b1 || bus.DU_O !== pack3(1, 2, 3)) begin
          errors++;
          $display("FAIL first_group got vu=%b du=%h want vu=1 du=%h", bus.VU_O, bus.DU_O, pack3(1, 2, 3));
        end
      end
    end
    checks++;
    if (pulses !== 3 || bus.DU_O !== pack3(7, 8, 9)) begin
      errors++;
      $display("FAIL continuous_count got pulses=%0d du=%h want 3 du=%h", pulses, bus.DU_O, pack3(7, 8, 9));
    end
    idle_inputs();
  endtask

  task automatic test_gapped();
    sample_t vals[3];
    vals[0] = sample_t'(-1024);
    vals[1] = sample_t'(1023);
    vals[2] = sample_t'(-1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < 3; g++) begin
        bus.VIN = (g == 0);
        bus.DIN = (g == 0) ? vals[i] : sample_t'($urandom);
        tick();
        checks++;
        if ({bus.VU_O, bus.DU_O} !== {exp_vu_o, exp_du_o}) begin
          errors++;
          $display("FAIL gapped_pack cyc=%0d got vu=%b du=%h want vu=%b du=%h",
                   cyc, bus.VU_O, bus.DU_O, exp_vu_o, exp_du_o);
        end
      end
    end
    checks++;
    if (pulses !== 1 || bus.DU_O !== pack3(vals[0], vals[1], vals[2])) begin
      errors++;
      $display("FAIL gapped_lanes got pulses=%0d du=%h want 1 du=%h",
               pulses, bus.DU_O, pack3(vals[0], vals[1], vals[2]));
    end
    idle_inputs();
  endtask

  // Drives one serializer cycle and compares the whole serial output side.
  task automatic ser_step(input logic v, input logic [W-1:0] d);
    bus.VU_I = v;
    bus.DU_I = d;
    tick();
    checks++;
    if ({bus.VOUT, bus.DOUT, bus.OVF} !== {exp_vout, exp_dout, exp_ovf}) begin
      errors++;
      $display("FAIL serial_out cyc=%0d got vout=%b dout=%h ovf=%b want vout=%b dout=%h ovf=%b",
               cyc, bus.VOUT, bus.DOUT, bus.OVF, exp_vout, exp_dout, exp_ovf);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ser_step(1'b1, pack3(10, 20, 30));
    ser_step(1'b0, '0);
    ser_step(1'b0, '0);
    ser_step(1'b1, pack3(40, 50, 60));
    for (int i = 0; i < 6; i++) ser_step(1'b0, '0);
    checks++;
    if (seen_q.size() != 6 || seen_q[0] !== 10 || seen_q[2] !== 30 || seen_q[3] !== 40 ||
        seen_q[5] !== 60 || bus.OVF !== 1'b0) begin
      errors++;
      $display("FAIL back_to_back got %0d values ovf=%b want 10..60 ovf=0", seen_q.size(), bus.OVF);
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    do_reset();
    ser_step(1'b1, pack3(10, 20, 30));
    ser_step(1'b1, pack3(40, 50, 60));
    for (int i = 0; i < 6; i++) ser_step(1'b0, '0);
    checks++;
    if (seen_q.size() != 3 || seen_q[0] !== 10 || seen_q[1] !== 20 || seen_q[2] !== 30 ||
        bus.OVF !== 1'b1 || bus.VOUT !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drop got %0d values ovf=%b vout=%b want 10,20,30 ovf=1 vout=0",
               seen_q.size(), bus.OVF, bus.VOUT);
    end
    ser_step(1'b1, pack3(1, 2, 3));
    for (int i = 0; i < 4; i++) ser_step(1'b0, '0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.OVF !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got ovf=%b want 0", bus.OVF);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_group();
    do_reset();
    bus.VIN = 1'b1;
    bus.DIN = sample_t'(100);
    tick();
    bus.DIN = sample_t'(200);
    tick();
    rst_n   = 1'b0;
    bus.DIN = sample_t'(555);
    tick();
    rst_n  = 1'b1;
    pulses = 0;
    checks++;
    if ({bus.DU_O, bus.VU_O, bus.DOUT, bus.VOUT, bus.OVF} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs du_o=%h vu_o=%b dout=%h vout=%b ovf=%b required all zero",
               bus.DU_O, bus.VU_O, bus.DOUT, bus.VOUT, bus.OVF);
    end
    for (int v = 7; v <= 10; v++) begin
      bus.VIN = (v <= 9);
      bus.DIN = sample_t'(v);
      tick();
      checks++;
      if ({bus.VU_O, bus.DU_O} !== {exp_vu_o, exp_du_o}) begin
        errors++;
        $display("FAIL reset_mid_pack cyc=%0d got vu=%b du=%h want vu=%b du=%h",
                 cyc, bus.VU_O, bus.DU_O, exp_vu_o, exp_du_o);
      end
    end
    checks++;
    if (pulses !== 1 || bus.DU_O !== pack3(7, 8, 9)) begin
      errors++;
      $display("FAIL reset_mid_group got pulses=%0d du=%h want 1 du=%h", pulses, bus.DU_O, pack3(7, 8, 9));
    end
    idle_inputs();
  endtask

  task automatic test_end_to_end();
    logic         dl_v[4];
    logic [W-1:0] dl_d[4];
    sample_t      sent_q[$];
    int           n_cycles;
    int           n_whole;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      dl_v[i] = 1'b0;
      dl_d[i] = '0;
    end
    n_cycles = 0;
    while (sent_q.size() < 300 || n_cycles < 40) begin
      if (sent_q.size() < 300) begin
        bus.VIN = ($urandom_range(0, 3) != 0);
        bus.DIN = sample_t'($urandom);
        if (bus.VIN) sent_q.push_back(bus.DIN);
      end else begin
        bus.VIN = 1'b0;
        n_cycles++;
      end
      bus.VU_I = dl_v[3];
      bus.DU_I = dl_d[3];
      tick();
      for (int i = 3; i > 0; i--) begin
        dl_v[i] = dl_v[i-1];
        dl_d[i] = dl_d[i-1];
      end
      dl_v[0] = bus.VU_O;
      dl_d[0] = bus.DU_O;
      checks++;
      if ({bus.VU_O, bus.DU_O, bus.VOUT, bus.DOUT, bus.OVF} !==
          {exp_vu_o, exp_du_o, exp_vout, exp_dout, exp_ovf}) begin
        errors++;
        $display("FAIL loopback_cycle cyc=%0d got vu=%b du=%h vout=%b dout=%h ovf=%b want vu=%b du=%h vout=%b dout=%h ovf=%b",
                 cyc, bus.VU_O, bus.DU_O, bus.VOUT, bus.DOUT, bus.OVF,
                 exp_vu_o, exp_du_o, exp_vout, exp_dout, exp_ovf);
      end
    end
    n_whole = (sent_q.size() / P) * P;
    checks++;
    if (seen_q.size() != n_whole || bus.OVF !== 1'b0) begin
      errors++;
      $display("FAIL loopback_length got %0d samples ovf=%b want %0d ovf=0", seen_q.size(), bus.OVF, n_whole);
    end
    for (int i = 0; i < n_whole && i < seen_q.size(); i++) begin
      checks++;
      if (seen_q[i] !== sent_q[i]) begin
        errors++;
        $display("FAIL loopback_sample idx=%0d got %h want %h", i, seen_q[i], sent_q[i]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    pulses = 0;
    test_reset();
    test_continuous();
    test_gapped();
    test_back_to_back();
    test_overflow();
    test_reset_mid_group();
    test_end_to_end();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout at cyc=%0d", cyc);
    $fatal(1, "bench timeout");
  end

endmodule
